impulse_level_decoder: RTL
==========================

Name: impulse_level_decoder

Overview:
- Receiving end of the edge-impulse scheme: a transmitter turns the rising and falling edges of a level x into short impulses on two lines, zp for rising and zn for falling.
- This block synchronizes both impulse lines into the clock domain and measures each impulse width in clock cycles.
- It accepts only impulses whose width is in range and rebuilds the original level x from the accepted impulses.
- It flags malformed, redundant or conflicting impulses on sticky error bits.

Parameters:
- SYNC_STAGES, 2: flip-flop synchronizer depth per impulse line; legal values are 2 or more.
- MIN_W, 1: minimum accepted impulse width, in clock cycles, measured on the synchronized signal.
- MAX_W, 8: maximum accepted impulse width, in clock cycles; MIN_W ≤ MAX_W is required.
- CW, 4: width counter bits; must satisfy 2^CW − 1 ≥ MAX_W + 1.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous reset, active-high.
- zp  in  1  rising-edge impulse line; asynchronous to clock.
- zn  in  1  falling-edge impulse line; asynchronous to clock.
- err_clear  in  1  synchronous clear of both sticky error bits.
- x  out  1  reconstructed level, registered.
- ev  out  1  one-cycle strobe, high in the cycle x is updated by an accepted impulse.
- err  out  2  sticky errors: bit 0 = width out of range; bit 1 = redundant or conflicting impulse.

Behaviour:
- Reset is asynchronous and active-high; one clock domain.
- While reset is high:
  - x=0, ev=0, err=00.
  - Synchronizer flops = 0, counters = 0, both channel FSMs in ARM.
- Synchronizer: zp and zn each pass through SYNC_STAGES flops, giving sp and sn.
- All widths and timing below are counted on sp and sn.
- Per-channel FSM, identical for p and n:
  - ARM: wait for the synchronized line to read 0, then go to IDLE. This discards an impulse already in progress when reset is released.
  - IDLE: on s=1, set cnt=1 and go to MEAS.
  - MEAS, s=1: cnt increments, saturating at MAX_W+1.
  - MEAS, s=0: produce a one-cycle internal event and go to IDLE. The event is valid when MIN_W ≤ cnt ≤ MAX_W, otherwise invalid.
- Event resolution happens in the cycle of the MEAS→IDLE transition. Outputs are registered and visible after the next rising clock edge.
  - Invalid event on either channel: set err[0]. That channel's event is discarded.
  - Valid p only, x=0: x←1, ev=1.
  - Valid n only, x=1: x←0, ev=1.
  - Valid p with x=1, or valid n with x=0: redundant. Set err[1]; x unchanged; ev=0.
  - Valid p and valid n in the same cycle: conflict. Set err[1]; x unchanged; ev=0.
- Latency: x and ev change at the first clock edge after the cycle in which the synchronized line first reads 0 following a high run. Measured from the raw falling edge of zp or zn, this is SYNC_STAGES+1 edges (±1 edge of synchronizer uncertainty).
- ev is high for exactly one cycle per accepted event and never in two consecutive cycles for the same channel.
- err bits are sticky:
  - err_clear=1 clears both bits at the next edge.
  - If a new error is detected in the same cycle as err_clear, the new error's bit is set (set wins) and the other bit clears.
- Counter saturation: an impulse held high indefinitely keeps cnt at MAX_W+1. It yields exactly one invalid event when the line finally falls. x is never changed mid-impulse.
- Reset asserted mid-impulse: state is cleared immediately. After release, a channel whose line is still high stays in ARM until the line reads 0, and no event results from that impulse.

Test Plan:
- Reset release, then zp high for 3 cycles, then low → x goes 0→1 at SYNC_STAGES+1=3 edges after zp falls; ev high exactly 1 cycle; err=00.
- With x=1, zn high for 5 cycles, then low → x goes 1→0 with one ev pulse. A following zn of 2 cycles → x stays 0, ev=0, err=10.
- zp held high for 12 cycles (MAX_W=8) → x unchanged, ev=0, err=01. Then assert err_clear for 1 cycle → err=00.
- zp and zn both 3 cycles wide with identical timing, x=0 → x stays 0, ev=0, err=10.
- Assert reset during the 2nd cycle of a 4-cycle zp impulse, release while zp is still high → no ev, x=0. The next clean 3-cycle zp → x=1.
- err_clear=1 in the same cycle as a detected width error, with err=10 beforehand → err=01 afterwards.

Source files
------------

// File: rtl/impulse_level_decoder.sv
// Rebuilds a level from rising/falling edge impulses on zp/zn, with width
// qualification per impulse and sticky error reporting.
module impulse_level_decoder #(
  parameter int SYNC_STAGES = 2,
  parameter int MIN_W       = 1,
  parameter int MAX_W       = 8,
  parameter int CW          = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       zp,
  input  logic       zn,
  input  logic       err_clear,
  output logic       x,
  output logic       ev,
  output logic [1:0] err
);

  typedef enum logic [1:0] {ARM, IDLE, MEAS} state_t;

  localparam logic [CW-1:0] C_MIN = CW'(MIN_W);
  localparam logic [CW-1:0] C_MAX = CW'(MAX_W);
  localparam logic [CW-1:0] C_SAT = CW'(MAX_W + 1);

  logic [SYNC_STAGES-1:0] r_sync_p;
  logic [SYNC_STAGES-1:0] r_sync_n;
  logic [SYNC_STAGES-1:0] r_prime;
  logic [1:0]             w_s;
  logic                   w_primed;

  state_t                 r_state     [2];
  state_t                 w_state_nxt [2];
  logic [CW-1:0]          r_cnt       [2];
  logic [CW-1:0]          w_cnt_nxt   [2];
  logic [1:0]             w_evt;
  logic [1:0]             w_valid;

  logic                   r_x;
  logic                   r_ev;
  logic [1:0]             r_err;
  logic                   w_vp;
  logic                   w_vn;
  logic                   w_x_nxt;
  logic                   w_ev_nxt;
  logic [1:0]             w_err_set;

  assign w_s      = {r_sync_n[SYNC_STAGES-1], r_sync_p[SYNC_STAGES-1]};
  assign w_primed = r_prime[SYNC_STAGES-1];

  // r_prime marks when the synchronizer output reflects the real line again
  // after reset; ARM ignores the reset-cleared zeros still in the chain.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_sync_p <= '0;
      r_sync_n <= '0;
      r_prime  <= '0;
    end else begin
      r_sync_p <= {r_sync_p[SYNC_STAGES-2:0], zp};
      r_sync_n <= {r_sync_n[SYNC_STAGES-2:0], zn};
      r_prime  <= {r_prime[SYNC_STAGES-2:0], 1'b1};
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int unsigned ch = 0; ch < 2; ch++) begin
        r_state[ch] <= ARM;
        r_cnt[ch]   <= '0;
      end
    end else begin
      for (int unsigned ch = 0; ch < 2; ch++) begin
        r_state[ch] <= w_state_nxt[ch];
        r_cnt[ch]   <= w_cnt_nxt[ch];
      end
    end
  end

  always_comb begin
    w_evt   = '0;
    w_valid = '0;
    for (int unsigned ch = 0; ch < 2; ch++) begin
      w_state_nxt[ch] = r_state[ch];
      w_cnt_nxt[ch]   = r_cnt[ch];
      unique case (r_state[ch])
        ARM: begin
          if (w_primed && !w_s[ch]) w_state_nxt[ch] = IDLE;
        end
        IDLE: begin
          if (w_s[ch]) begin
            w_cnt_nxt[ch]   = CW'(1);
            w_state_nxt[ch] = MEAS;
          end
        end
        MEAS: begin
          if (w_s[ch]) begin
            if (r_cnt[ch] != C_SAT) w_cnt_nxt[ch] = r_cnt[ch] + CW'(1);
          end else begin
            w_evt[ch]       = 1'b1;
            w_valid[ch]     = (r_cnt[ch] >= C_MIN) && (r_cnt[ch] <= C_MAX);
            w_state_nxt[ch] = IDLE;
          end
        end
        default: w_state_nxt[ch] = ARM;
      endcase
    end
  end

  assign w_vp = w_evt[0] & w_valid[0];
  assign w_vn = w_evt[1] & w_valid[1];

  always_comb begin
    w_x_nxt      = r_x;
    w_ev_nxt     = 1'b0;
    w_err_set    = '0;
    w_err_set[0] = (w_evt[0] & ~w_valid[0]) | (w_evt[1] & ~w_valid[1]);
    if (w_vp && w_vn) begin
      w_err_set[1] = 1'b1;
    end else if (w_vp) begin
      if (r_x) w_err_set[1] = 1'b1;
      else begin
        w_x_nxt  = 1'b1;
        w_ev_nxt = 1'b1;
      end
    end else if (w_vn) begin
      if (!r_x) w_err_set[1] = 1'b1;
      else begin
        w_x_nxt  = 1'b0;
        w_ev_nxt = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_x   <= 1'b0;
      r_ev  <= 1'b0;
      r_err <= '0;
    end else begin
      r_x   <= w_x_nxt;
      r_ev  <= w_ev_nxt;
      r_err <= w_err_set | (r_err & {2{~err_clear}});
    end
  end

  assign x   = r_x;
  assign ev  = r_ev;
  assign err = r_err;

endmodule
